// File: rtl/dbus_access_ctrl.sv
// Load/store data-bus access controller: alignment check, lane steering, load extension.
// Latency: accept at N, bus request from N+1, response one cycle after dbus_ok (min N+2); misaligned response at N+1.
// Backpressure: req_ready only in IDLE without flush; the bus request is held stable until dbus_ok.

package dbus_pkg;
    typedef enum logic [3:0] {
        OP_NOP, LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD, OP_ADD
    } instruction_type;

    typedef enum logic [1:0] {
        MSIZE1, MSIZE2, MSIZE4, MSIZE8
    } msize_t;
endpackage

module dbus_access_ctrl
    import dbus_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  instruction_type req_op,
    input  logic [63:0]     req_addr,
    input  logic [63:0]     req_wdata,
    output logic            req_ready,
    output logic            resp_valid,
    output logic [63:0]     resp_data,
    output logic            resp_misaligned,
    input  logic            flush,
    output logic            dbus_valid,
    output logic [63:0]     dbus_addr,
    output msize_t          dbus_size,
    output logic [7:0]      dbus_strobe,
    output logic [63:0]     dbus_data,
    input  logic            dbus_ok,
    input  logic [63:0]     dbus_rdata
);

    typedef enum logic [1:0] {IDLE, BUS, RESP, DRAIN} state_t;

    state_t      state;
    logic [63:0] addr_q;
    msize_t      size_q;
    logic [7:0]  strobe_q;
    logic [63:0] data_q;
    logic        store_q;
    logic        signed_q;
    logic        misaligned_q;
    logic [63:0] result_q;

    // Request decode, evaluated against the live request inputs
    msize_t      acc_size;
    logic        acc_mem;
    logic        acc_store;
    logic        acc_signed;
    logic        acc_aligned;
    logic [7:0]  acc_base_mask;
    logic [63:0] acc_wmask;
    logic [7:0]  acc_strobe;
    logic [63:0] acc_data;

    // Load result extraction from the raw bus word
    logic [63:0] rd_lane;
    logic [63:0] ld_result;

    logic        accept;

    // Decode op into size, direction, extension mode and legality; steer store lanes
    always_comb begin
        acc_size      = MSIZE8;
        acc_mem       = 1'b1;
        acc_store     = 1'b0;
        acc_signed    = 1'b0;
        acc_aligned   = 1'b0;
        acc_base_mask = 8'hFF;
        acc_wmask     = '1;
        acc_strobe    = '0;
        acc_data      = '0;
        case (req_op)
            LB:      begin acc_size = MSIZE1; acc_signed = 1'b1; end
            LH:      begin acc_size = MSIZE2; acc_signed = 1'b1; end
            LW:      begin acc_size = MSIZE4; acc_signed = 1'b1; end
            LD:      acc_size = MSIZE8;
            LBU:     acc_size = MSIZE1;
            LHU:     acc_size = MSIZE2;
            LWU:     acc_size = MSIZE4;
            SB:      begin acc_size = MSIZE1; acc_store = 1'b1; end
            SH:      begin acc_size = MSIZE2; acc_store = 1'b1; end
            SW:      begin acc_size = MSIZE4; acc_store = 1'b1; end
            SD:      begin acc_size = MSIZE8; acc_store = 1'b1; end
            default: acc_mem = 1'b0;
        endcase
        case (acc_size)
            MSIZE1: begin
                acc_aligned   = 1'b1;
                acc_base_mask = 8'h01;
                acc_wmask     = 64'h0000_0000_0000_00FF;
            end
            MSIZE2: begin
                acc_aligned   = (req_addr[0] == 1'b0);
                acc_base_mask = 8'h03;
                acc_wmask     = 64'h0000_0000_0000_FFFF;
            end
            MSIZE4: begin
                acc_aligned   = (req_addr[1:0] == 2'b00);
                acc_base_mask = 8'h0F;
                acc_wmask     = 64'h0000_0000_FFFF_FFFF;
            end
            default: begin
                acc_aligned   = (req_addr[2:0] == 3'b000);
                acc_base_mask = 8'hFF;
                acc_wmask     = '1;
            end
        endcase
        if (acc_store) begin
            acc_strobe = acc_base_mask << req_addr[2:0];
            acc_data   = (req_wdata & acc_wmask) << {req_addr[2:0], 3'b000};
        end
    end

    // Pick the addressed lane out of the read word and extend it to 64 bits
    always_comb begin
        rd_lane   = dbus_rdata >> {addr_q[2:0], 3'b000};
        ld_result = rd_lane;
        case (size_q)
            MSIZE1:  ld_result = signed_q ? {{56{rd_lane[7]}},  rd_lane[7:0]}  : {56'b0, rd_lane[7:0]};
            MSIZE2:  ld_result = signed_q ? {{48{rd_lane[15]}}, rd_lane[15:0]} : {48'b0, rd_lane[15:0]};
            MSIZE4:  ld_result = signed_q ? {{32{rd_lane[31]}}, rd_lane[31:0]} : {32'b0, rd_lane[31:0]};
            default: ld_result = rd_lane;
        endcase
        if (store_q) begin
            ld_result = '0;
        end
    end

    assign req_ready = (state == IDLE) && !flush && !reset;
    assign accept    = req_valid && req_ready;

    // Transaction FSM; request fields are frozen at accept so the bus sees stable values
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            addr_q       <= '0;
            size_q       <= MSIZE1;
            strobe_q     <= '0;
            data_q       <= '0;
            store_q      <= 1'b0;
            signed_q     <= 1'b0;
            misaligned_q <= 1'b0;
            result_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q       <= req_addr;
                        size_q       <= acc_size;
                        strobe_q     <= acc_strobe;
                        data_q       <= acc_data;
                        store_q      <= acc_store;
                        signed_q     <= acc_signed;
                        misaligned_q <= !(acc_mem && acc_aligned);
                        result_q     <= '0;
                        state        <= (acc_mem && acc_aligned) ? BUS : RESP;
                    end
                end
                BUS: begin
                    if (dbus_ok) begin
                        if (flush) begin
                            state <= IDLE;
                        end else begin
                            result_q <= ld_result;
                            state    <= RESP;
                        end
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (dbus_ok) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign dbus_valid      = (state == BUS) || (state == DRAIN);
    assign dbus_addr       = addr_q;
    assign dbus_size       = size_q;
    assign dbus_strobe     = strobe_q;
    assign dbus_data       = data_q;
    assign resp_valid      = (state == RESP) && !flush;
    assign resp_misaligned = resp_valid && misaligned_q;
    assign resp_data       = result_q;

endmodule
